hold_ctrl: RTL

Upstream control stage for the up-counter: turns two raw, bouncy push-buttons (pause/resume and single-step) into the counter's `hold` input. Both inputs pass through a two-flop synchronizer and a debouncer. A small state machine then decides, cycle by cycle, whether the counter is held, free-running, or released for exactly one count.

---
 rtl/hold_ctrl_pkg.sv | 12 +
 rtl/hold_ctrl_if.sv | 23 ++
 rtl/hold_ctrl_debounce.sv | 60 ++++++
 rtl/hold_ctrl.sv | 66 ++++++
 4 files changed

// File: rtl/hold_ctrl_pkg.sv
// rtl/hold_ctrl_pkg.sv - shared types and defaults for the hold controller
package hold_ctrl_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'b00,
        RUNNING = 2'b01,
        STEP    = 2'b10
    } hold_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/hold_ctrl_if.sv
// rtl/hold_ctrl_if.sv - button inputs and counter-control outputs of hold_ctrl
interface hold_ctrl_if;

    logic btn_pause;
    logic btn_step;
    logic hold;
    logic running;

    modport master (
        output btn_pause,
        output btn_step,
        input  hold,
        input  running
    );

    modport slave (
        input  btn_pause,
        input  btn_step,
        output hold,
        output running
    );

endinterface

// File: rtl/hold_ctrl_debounce.sv
// rtl/hold_ctrl_debounce.sv - two-flop synchronizer, debouncer and rising-edge press pulse
module debounce
    import hold_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    // The count clears on the flip, so it never needs to hold DEBOUNCE_CYCLES itself.
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;

    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = ~db_q;
                rise_d = ~db_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign level = db_q;
    assign rise  = rise_q;

endmodule

// File: rtl/hold_ctrl.sv
// rtl/hold_ctrl.sv - turns debounced pause/step buttons into the counter hold signal
module hold_ctrl
    import hold_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    hold_ctrl_if.slave bus
);

    logic        pause_rise;
    logic        step_rise;
    logic [1:0]  levels_unused;
    hold_state_t state_q;
    hold_state_t state_d;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_pause),
        .level (levels_unused[0]),
        .rise  (pause_rise)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_step),
        .level (levels_unused[1]),
        .rise  (step_rise)
    );

    // Pause outranks step when both land in the same cycle; STEP drops anything arriving.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PAUSED: begin
                if (pause_rise) begin
                    state_d = RUNNING;
                end else if (step_rise) begin
                    state_d = STEP;
                end
            end
            RUNNING: begin
                if (pause_rise) begin
                    state_d = PAUSED;
                end
            end
            STEP:    state_d = PAUSED;
            default: state_d = PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.hold    = (state_q != RUNNING) && (state_q != STEP);
    assign bus.running = (state_q == RUNNING);

endmodule
